complex_prod_accumulator: RTL and testbench
===========================================

// Module: complex_prod_accumulator
// PURPOSE
//  Downstream stage of complex_array_mul. Consumes its stream of complex
//  products (re/im), accumulates N of them at full precision (complex dot
//  product), then presents the sum on a ready/valid output until taken.
//  Feeds the ALU result/write-back logic.
// PARAMETERS
//  PW      33                 product component width (signed); 16x16 complex -> 33
//  N       16                 products per accumulation; N >= 2
//  CNTW    $clog2(N)          product counter width
//  AW      PW+$clog2(N)       accumulator/result width (signed); exact, never overflows
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous reset, active-low
//  start      in   1    pulse: begin new accumulation (honoured only in IDLE)
//  prod_valid in   1    product beat valid
//  prod_re    in   PW   product real part, signed
//  prod_im    in   PW   product imaginary part, signed
//  in_ready   out  1    stage accepts a beat this cycle
//  acc_ready  in   1    downstream takes result
//  acc_valid  out  1    result valid; held until acc_ready
//  acc_re     out  AW   accumulated real part, signed
//  acc_im     out  AW   accumulated imaginary part, signed
//  busy       out  1    state != IDLE
//  count      out  CNTW beats accepted in current accumulation
// BEHAVIOUR
//  - Reset (rst_n=0, async, immediate): state IDLE; acc_re/acc_im/count = 0;
//    acc_valid, in_ready, busy = 0. Applies mid-operation: partial sum discarded.
//  - Accept = prod_valid & in_ready. prod_valid while in_ready=0 is ignored;
//    upstream holds the beat. All outputs registered; in_ready = (state==ACCUM).
//  - FSM states IDLE, ACCUM, HOLD:
//    IDLE : start=1 -> ACCUM; acc/count cleared same edge. Otherwise stay.
//    ACCUM: on accept, acc += sign_ext(prod) to AW bits, count += 1.
//           Accept with count==N-1 -> HOLD; final sum registered that edge;
//           acc_valid=1, in_ready=0 next cycle (latency 1 cycle after Nth beat).
//           Gaps in prod_valid: no change, wait indefinitely.
//    HOLD : acc_valid=1, acc_re/acc_im stable. acc_ready=1 -> IDLE, acc_valid
//           falls next cycle; acc values kept until next start.
//  - start outside IDLE ignored, incl. the cycle HOLD completes (start then
//    honoured the following cycle in IDLE).
//  - count wraps to 0 on entry to HOLD; reads 0 in HOLD and IDLE.
//  - Arithmetic: two's complement, full precision; sum of N min-value
//    products (-2^(PW-1)*N) representable, so no saturation/overflow logic.
// STRUCTURE
//  - Package complex_alu_pkg: state enum (IDLE/ACCUM/HOLD), default PW/N
//    constants, sign-extension function PW->AW.
//  - Sub-module complex_acc_lane: one signed AW-bit accumulator with
//    clear/add enables; instantiated twice (re, im). FSM + counter in top.
// TESTING (bench uses N=4, PW=33)
//  1. rst_n=0 at t=0 -> all outputs 0; release, idle 5 cycles -> no change.
//  2. start; beats (1,2),(3,-4),(5,6),(-7,8) back-to-back -> acc_valid=1
//     one cycle after 4th accept, acc=(2,12), in_ready=0.
//  3. Case 2 with acc_ready=0 for 5 cycles + prod_valid=1 driven -> acc_valid,
//     (2,12) held, no beat accepted; acc_ready=1 -> IDLE, busy=0 next cycle.
//  4. Four beats (-2^32,-2^32) -> acc=(-2^34,-2^34) exact, no wrap;
//     four beats (2^32-1, 0) -> acc_re = 2^34-4.
//  5. start, 2 beats (10,10) then rst_n pulse -> IDLE, acc=0 immediately;
//     start + 4 beats (1,1) -> acc=(4,4), no residue of old sum.
//  6. prod_valid gaps of 3 cycles between beats, start pulsed in ACCUM ->
//     start ignored, count 1..3 then HOLD, sum correct.

Source files
------------

// File: rtl/complex_prod_accumulator_pkg.sv
// Shared types and helpers for the complex product accumulator:
// FSM state encoding, default sizing and PW->AW sign extension.
package complex_alu_pkg;

   localparam int PW_DEF = 33;
   localparam int N_DEF  = 16;

   // Working width of the sign-extension helper; every AW in use must fit.
   localparam int SEXT_W = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_e;

   // Treats bit w-1 of v as the sign bit and replicates it upward.
   function automatic logic signed [SEXT_W-1:0] sign_ext(input logic [SEXT_W-1:0] v,
                                                        input int w);
      logic signed [SEXT_W-1:0] t;
      t = $signed(v << (SEXT_W - w));
      return t >>> (SEXT_W - w);
   endfunction

endpackage

// File: rtl/complex_prod_accumulator_if.sv
// Product-in / result-out bundle of the complex product accumulator.
// master = upstream/downstream environment, slave = the accumulator.
interface complex_prod_accumulator_if #(
   parameter int PW = 33,
   parameter int N  = 16
);
   localparam int CNTW = $clog2(N);
   localparam int AW   = PW + $clog2(N);

   logic                 start;
   logic                 prod_valid;
   logic signed [PW-1:0] prod_re;
   logic signed [PW-1:0] prod_im;
   logic                 in_ready;
   logic                 acc_ready;
   logic                 acc_valid;
   logic signed [AW-1:0] acc_re;
   logic signed [AW-1:0] acc_im;
   logic                 busy;
   logic [CNTW-1:0]      count;

   modport master (
      output start, prod_valid, prod_re, prod_im, acc_ready,
      input  in_ready, acc_valid, acc_re, acc_im, busy, count
   );

   modport slave (
      input  start, prod_valid, prod_re, prod_im, acc_ready,
      output in_ready, acc_valid, acc_re, acc_im, busy, count
   );
endinterface

// File: rtl/complex_prod_accumulator_lane.sv
// One signed accumulator lane: clear has priority over add; the addend is
// sign-extended from PW to AW so the running sum is exact.
module complex_acc_lane
   import complex_alu_pkg::*;
#(
   parameter int PW = 33,
   parameter int AW = 37
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr_i,
   input  logic                 add_i,
   input  logic signed [PW-1:0] addend_i,
   output logic signed [AW-1:0] acc_o
);

   logic signed [AW-1:0] addend_ext;
   logic signed [AW-1:0] acc_d, acc_q;

   assign addend_ext = AW'(sign_ext(SEXT_W'(addend_i), PW));

   // NOTE: default assignment first so no path leaves acc_d unassigned (no latch).
   always_comb begin
      acc_d = acc_q;
      if (clr_i)      acc_d = '0;
      else if (add_i) acc_d = acc_q + addend_ext;
   end

   // NOTE: non-blocking for registered state so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) acc_q <= '0;
      else        acc_q <= acc_d;
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/complex_prod_accumulator.sv
// Accumulates N complex products into an exact AW-bit sum and holds the
// result on a ready/valid output until it is taken.
module complex_prod_accumulator
   import complex_alu_pkg::*;
#(
   parameter int PW = PW_DEF,
   parameter int N  = N_DEF
) (
   input  logic                             clk,
   input  logic                             rst_n,
   complex_prod_accumulator_if.slave        bus
);

   localparam int CNTW = $clog2(N);
   localparam int AW   = PW + $clog2(N);

   state_e          state_q;
   logic [CNTW-1:0] count_q;
   logic            in_ready_q;
   logic            acc_valid_q;
   logic            busy_q;

   logic accept;
   logic lane_clr;

   assign accept   = bus.prod_valid & in_ready_q;
   assign lane_clr = (state_q == IDLE) & bus.start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         count_q     <= '0;
         in_ready_q  <= 1'b0;
         acc_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q    <= ACCUM;
                  count_q    <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            ACCUM: begin
               if (accept) begin
                  // The Nth beat closes the accumulation; count reads 0 from HOLD on.
                  if (count_q == CNTW'(N - 1)) begin
                     state_q     <= HOLD;
                     count_q     <= '0;
                     in_ready_q  <= 1'b0;
                     acc_valid_q <= 1'b1;
                  end else begin
                     count_q <= count_q + 1'b1;
                  end
               end
            end
            HOLD: begin
               if (bus.acc_ready) begin
                  state_q     <= IDLE;
                  acc_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end
            end
            default: begin
               state_q     <= IDLE;
               count_q     <= '0;
               in_ready_q  <= 1'b0;
               acc_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   complex_acc_lane #(.PW(PW), .AW(AW)) u_lane_re (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (lane_clr),
      .add_i    (accept),
      .addend_i (bus.prod_re),
      .acc_o    (bus.acc_re)
   );

   complex_acc_lane #(.PW(PW), .AW(AW)) u_lane_im (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (lane_clr),
      .add_i    (accept),
      .addend_i (bus.prod_im),
      .acc_o    (bus.acc_im)
   );

   assign bus.in_ready  = in_ready_q;
   assign bus.acc_valid = acc_valid_q;
   assign bus.busy      = busy_q;
   assign bus.count     = count_q;

endmodule

// File: tb/tb_complex_prod_accumulator.sv
// Directed bench for complex_prod_accumulator at N=4, PW=33; expected sums
// are hand-computed constants.
module tb_complex_prod_accumulator;

   localparam int PW = 33;
   localparam int N  = 4;

   logic clk;
   logic rst_n;

   int n_cmp = 0;
   int n_bad = 0;

   complex_prod_accumulator_if #(.PW(PW), .N(N)) bus_if ();

   complex_prod_accumulator #(.PW(PW), .N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion, required finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one beat and hold it until the DUT accepts it.
   task automatic send(input logic signed [63:0] re, input logic signed [63:0] im);
      logic took;
      took = 1'b0;
      bus_if.prod_valid = 1'b1;
      bus_if.prod_re    = PW'(re);
      bus_if.prod_im    = PW'(im);
      for (int i = 0; i < 50; i++) begin
         took = bus_if.in_ready;
         step();
         if (took) break;
      end
      bus_if.prod_valid = 1'b0;
      if (!took) check("send_timeout", 0, 1);
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_acc_valid"}, bus_if.acc_valid, 0);
      check({tag, "_in_ready"},  bus_if.in_ready,  0);
      check({tag, "_busy"},      bus_if.busy,      0);
      check({tag, "_count"},     bus_if.count,     0);
      check({tag, "_acc_re"},    bus_if.acc_re,    0);
      check({tag, "_acc_im"},    bus_if.acc_im,    0);
   endtask

   initial begin
      rst_n             = 1'b0;
      bus_if.start      = 1'b0;
      bus_if.prod_valid = 1'b0;
      bus_if.prod_re    = '0;
      bus_if.prod_im    = '0;
      bus_if.acc_ready  = 1'b0;

      // 1: reset state, then idle without start
      step();
      step();
      check_idle_zero("reset");
      rst_n = 1'b1;
      repeat (5) step();
      check_idle_zero("idle5");

      // 2: four back-to-back beats
      bus_if.start = 1'b1;
      step();
      bus_if.start = 1'b0;
      check("start_busy", bus_if.busy, 1);
      check("start_in_ready", bus_if.in_ready, 1);
      check("start_count", bus_if.count, 0);
      send(1, 2);
      send(3, -4);
      check("b2b_count2", bus_if.count, 2);
      send(5, 6);
      send(-7, 8);
      check("b2b_acc_valid", bus_if.acc_valid, 1);
      check("b2b_in_ready", bus_if.in_ready, 0);
      check("b2b_acc_re", bus_if.acc_re, 2);
      check("b2b_acc_im", bus_if.acc_im, 12);
      check("b2b_count_hold", bus_if.count, 0);

      // 3: result held under back-pressure while beats are offered
      bus_if.prod_valid = 1'b1;
      bus_if.prod_re    = PW'(100);
      bus_if.prod_im    = PW'(100);
      for (int i = 0; i < 5; i++) begin
         step();
         check("hold_acc_valid", bus_if.acc_valid, 1);
         check("hold_in_ready", bus_if.in_ready, 0);
         check("hold_acc_re", bus_if.acc_re, 2);
         check("hold_acc_im", bus_if.acc_im, 12);
      end
      bus_if.prod_valid = 1'b0;
      bus_if.acc_ready  = 1'b1;
      bus_if.start      = 1'b1;   // coincides with HOLD completion: ignored
      step();
      bus_if.acc_ready = 1'b0;
      check("take_acc_valid", bus_if.acc_valid, 0);
      check("take_busy", bus_if.busy, 0);
      check("take_keep_re", bus_if.acc_re, 2);
      check("take_keep_im", bus_if.acc_im, 12);
      step();                     // start still high, now honoured in IDLE
      bus_if.start = 1'b0;
      check("restart_busy", bus_if.busy, 1);
      check("restart_clear_re", bus_if.acc_re, 0);

      // 4: extreme operands, exact sums
      for (int i = 0; i < 4; i++) send(-(64'sd1 <<< 32), -(64'sd1 <<< 32));
      check("min_acc_re", bus_if.acc_re, -(64'sd1 <<< 34));
      check("min_acc_im", bus_if.acc_im, -(64'sd1 <<< 34));
      bus_if.acc_ready = 1'b1;
      step();
      bus_if.acc_ready = 1'b0;
      bus_if.start     = 1'b1;
      step();
      bus_if.start = 1'b0;
      for (int i = 0; i < 4; i++) send((64'sd1 <<< 32) - 1, 0);
      check("max_acc_re", bus_if.acc_re, (64'sd1 <<< 34) - 4);
      check("max_acc_im", bus_if.acc_im, 0);
      bus_if.acc_ready = 1'b1;
      step();
      bus_if.acc_ready = 1'b0;

      // 5: asynchronous reset mid-accumulation
      bus_if.start = 1'b1;
      step();
      bus_if.start = 1'b0;
      send(10, 10);
      send(10, 10);
      check("pre_rst_count", bus_if.count, 2);
      check("pre_rst_acc_re", bus_if.acc_re, 20);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_zero("async_rst");
      #1;
      rst_n = 1'b1;
      step();
      bus_if.start = 1'b1;
      step();
      bus_if.start = 1'b0;
      for (int i = 0; i < 4; i++) send(1, 1);
      check("post_rst_acc_re", bus_if.acc_re, 4);
      check("post_rst_acc_im", bus_if.acc_im, 4);
      check("post_rst_valid", bus_if.acc_valid, 1);
      bus_if.acc_ready = 1'b1;
      step();
      bus_if.acc_ready = 1'b0;

      // 6: gaps between beats, start pulsed while accumulating
      bus_if.start = 1'b1;
      step();
      bus_if.start = 1'b0;
      send(7, -1);
      check("gap_count1", bus_if.count, 1);
      step();
      bus_if.start = 1'b1;
      step();
      bus_if.start = 1'b0;
      step();
      check("gap_count1_held", bus_if.count, 1);
      check("gap_sum1_re", bus_if.acc_re, 7);
      send(-3, 2);
      check("gap_count2", bus_if.count, 2);
      repeat (3) step();
      send(100, 0);
      check("gap_count3", bus_if.count, 3);
      check("gap_valid_low", bus_if.acc_valid, 0);
      repeat (3) step();
      send(-4, -5);
      check("gap_acc_valid", bus_if.acc_valid, 1);
      check("gap_acc_re", bus_if.acc_re, 100);
      check("gap_acc_im", bus_if.acc_im, -4);
      bus_if.acc_ready = 1'b1;
      step();
      bus_if.acc_ready = 1'b0;
      check("final_busy", bus_if.busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
